// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with a
// sticky TRAP state for unrecognised opcodes.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic        imem_req,
    input  logic        dmem_ready,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        br_taken,
    output logic [31:0] instr,
    output logic [2:0]  imm_sel,
    output logic        alu_src_a,
    output logic        alu_src_b,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        illegal,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        FETCH  = 3'b000,
        DECODE = 3'b001,
        EXEC   = 3'b010,
        MEM    = 3'b011,
        WB     = 3'b100,
        TRAP   = 3'b101
    } state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic        illegal_q, illegal_d;

    logic [6:0] opc;
    logic       is_lui, is_auipc, is_jal, is_jalr, is_branch;
    logic       is_load, is_store, is_opimm, is_op, is_legal;
    logic       rd_nz;

    assign opc       = instr_q[6:0];
    assign is_lui    = (opc == OPC_LUI);
    assign is_auipc  = (opc == OPC_AUIPC);
    assign is_jal    = (opc == OPC_JAL);
    assign is_jalr   = (opc == OPC_JALR);
    assign is_branch = (opc == OPC_BRANCH);
    assign is_load   = (opc == OPC_LOAD);
    assign is_store  = (opc == OPC_STORE);
    assign is_opimm  = (opc == OPC_OPIMM);
    assign is_op     = (opc == OPC_OP);
    assign is_legal  = is_lui | is_auipc | is_jal | is_jalr | is_branch |
                       is_load | is_store | is_opimm | is_op;
    assign rd_nz     = (instr_q[11:7] != 5'd0);

    // Datapath selects depend only on the latched opcode, so they are stable
    // across every state of an instruction.
    always_comb begin
        imm_sel = 3'b000;
        wb_sel  = 2'b00;
        if (is_load || is_opimm || is_jalr) imm_sel = 3'b000;
        else if (is_store)                  imm_sel = 3'b001;
        else if (is_branch)                 imm_sel = 3'b010;
        else if (is_lui || is_auipc)        imm_sel = 3'b011;
        else if (is_jal)                    imm_sel = 3'b100;
        if (is_load)                 wb_sel = 2'b01;
        else if (is_jal || is_jalr)  wb_sel = 2'b10;
        else if (is_lui)             wb_sel = 2'b11;
    end

    assign alu_src_a = is_auipc;
    assign alu_src_b = ~(is_op | is_branch);

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        illegal_d = illegal_q;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 2'b00;
        reg_we    = 1'b0;
        case (state_q)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    instr_d = imem_rdata;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (is_legal) begin
                    state_d = EXEC;
                end else begin
                    state_d   = TRAP;
                    illegal_d = 1'b1;
                end
            end
            EXEC: begin
                if (is_load || is_store) begin
                    state_d = MEM;
                end else if (is_branch) begin
                    pc_we   = 1'b1;
                    pc_sel  = br_taken ? 2'b01 : 2'b00;
                    state_d = FETCH;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                if (dmem_ready) begin
                    if (is_store) begin
                        pc_we   = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end
            end
            WB: begin
                reg_we  = rd_nz;
                pc_we   = 1'b1;
                pc_sel  = is_jal ? 2'b01 : (is_jalr ? 2'b10 : 2'b00);
                state_d = FETCH;
            end
            default: begin
                // TRAP and unused encodings: park until reset.
                state_d   = TRAP;
                illegal_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            instr_q   <= 32'h0000_0013;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            illegal_q <= illegal_d;
        end
    end

    assign instr   = instr_q;
    assign illegal = illegal_q;
    assign state   = state_q;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port: imem_rdata  input  32  instruction word from program memory.
REQ-004 SHALL have port: imem_valid  input  1  imem_rdata valid this cycle.
REQ-005 SHALL have port: imem_req  output  1  instruction fetch request.
REQ-006 SHALL have port: dmem_ready  input  1  data memory completes the access this cycle.
REQ-007 SHALL have port: dmem_req / dmem_we  output  1 each  data access request / store strobe.
REQ-008 SHALL have port: br_taken  input  1  branch comparison result from ALU, valid in EXEC.
REQ-009 SHALL have port: instr  output  32  latched instruction register, drives immediate generator.
REQ-010 SHALL have port: imm_sel  output  3  000 I, 001 S, 010 B, 011 U, 100 J.
REQ-011 SHALL have port: alu_src_a  output  1  0 rs1, 1 PC.
REQ-012 SHALL have port: alu_src_b  output  1  0 rs2, 1 immediate.
REQ-013 SHALL have port: pc_we  output  1  PC update strobe.
REQ-014 SHALL have port: pc_sel  output  2  00 PC+4, 01 PC+imm, 10 (rs1+imm)&~1.
REQ-015 SHALL have port: reg_we  output  1  register-file write strobe.
REQ-016 SHALL have port: wb_sel  output  2  00 ALU, 01 load data, 10 PC+4, 11 immediate.
REQ-017 SHALL have port: illegal  output  1  sticky illegal-opcode flag.
REQ-018 SHALL have port: state  output  3  current state encoding, for debug.

Function
REQ-019 SHALL implement states FETCH=000, DECODE=001, EXEC=010, MEM=011, WB=100, TRAP=101; others decode as TRAP.
REQ-020 SHALL, in FETCH, assert imem_req; on imem_valid=1, load imem_rdata into instr and move to DECODE the next cycle; otherwise stay.
REQ-021 SHALL, in DECODE, classify instr[6:0]: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OPIMM 0010011, OP 0110011; any other value goes to TRAP, else to EXEC.
REQ-022 SHALL drive imm_sel from the latched opcode in all states: I for LOAD/OPIMM/JALR, S for STORE, B for BRANCH, U for LUI/AUIPC, J for JAL, 000 for OP/illegal.
REQ-023 SHALL, in EXEC: LOAD/STORE to MEM; BRANCH to FETCH with pc_we=1, pc_sel=01 if br_taken else 00; all others to WB.
REQ-024 SHALL, in EXEC, drive alu_src_a=1 only for AUIPC and alu_src_b=1 for all classes except OP and BRANCH.
REQ-025 SHALL, in MEM, hold dmem_req=1 (dmem_we=1 for STORE) until dmem_ready=1; then LOAD to WB, STORE to FETCH with pc_we=1, pc_sel=00.
REQ-026 SHALL, in WB, pulse reg_we=1 and pc_we=1 for one cycle, then go to FETCH; wb_sel: LOAD 01, JAL/JALR 10, LUI 11, else 00; pc_sel: JAL 01, JALR 10, else 00.
REQ-027 SHALL suppress reg_we when instr[11:7]=0.
REQ-028 SHALL, in TRAP, hold illegal=1 and all strobes (imem_req, dmem_req, dmem_we, pc_we, reg_we) at 0 until reset.
REQ-029 SHALL drive all strobes as Moore outputs of state and instr; strobes are 0 in every state not naming them.
REQ-030 SHALL ignore imem_valid outside FETCH and dmem_ready outside MEM.
REQ-031 SHALL give per-instruction latency (zero-wait memory): BRANCH 3 cycles, OP/OPIMM/LUI/AUIPC/JAL/JALR 4, STORE 4, LOAD 5.

Reset
REQ-032 SHALL, when rst_n=0 at a rising edge, set state=FETCH, instr=32'h0000_0013 (NOP), illegal=0, regardless of current state including mid-MEM access.
REQ-033 SHALL present after reset: imem_req=1, all other strobes 0, imm_sel=000, pc_sel=00, wb_sel=00, alu_src_a=0, alu_src_b=1 (NOP is OPIMM).

Verification
REQ-034 SHALL verify ADDI 0x00500093, imem_valid=1 -> FETCH,DECODE,EXEC,WB; imm_sel=000; reg_we and pc_we high only in WB; back in FETCH on cycle 5.
REQ-035 SHALL verify BEQ 0x00000463 with br_taken=1 -> imm_sel=010, pc_we=1, pc_sel=01 in EXEC, no reg_we; with br_taken=0 -> pc_sel=00.
REQ-036 SHALL verify LW 0x0000A103 with dmem_ready low 3 cycles -> dmem_req held 4 cycles, then WB with wb_sel=01, reg_we=1.
REQ-037 SHALL verify SW 0x0020A023 -> imm_sel=001, dmem_we=1 in MEM, pc_we at MEM exit, reg_we never asserted.
REQ-038 SHALL verify opcode 0x0000007F -> TRAP, illegal=1 and held with all strobes 0 for 10 cycles; rst_n=0 one cycle -> FETCH, illegal=0.
REQ-039 SHALL verify JAL x0 0x0080006F -> imm_sel=100, pc_sel=01, wb_sel=10, reg_we=0 (rd=0).
